dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the single-cycle MIPS core's data port.
- Services core load/store requests with a configurable number of wait states and signals completion with a one-cycle ready pulse.
- Backs a word-addressed RAM plus a small MMIO window (LED register, optional free-running cycle counter).
- Sits between the core and the data store in the top level. It replaces the zero-latency combinational data memory once the core gains stall support.

Parameters:
- DEPTH, 64: RAM depth in 32-bit words; must be a power of two, ≥ 2.
- WAIT_CYCLES, 2: extra wait states per access, range 0..15.
- LED_ADDR, 32'hFFFF_FF00: byte address of the read/write LED register.
- CNT_ADDR, 32'hFFFF_FF04: byte address of the read-only cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; core holds req, we, addr and wdata stable until ready.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address from the core.
- wdata  in  32  store data.
- rdata  out  32  load data; valid only while ready = 1.
- ready  out  1  one-cycle completion pulse (registered).
- err  out  1  sticky error flag: misaligned or unmapped access.
- led  out  16  LED register bits [15:0].

Behaviour:
- Interface rules: one clock (clk); reset is synchronous and active-high.
- Reset values: rdata = 0, ready = 0, err = 0, led = 0, counter = 0, FSM = IDLE. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req = 1 at an edge accepts the request and latches addr, we and wdata.
  - If WAIT_CYCLES = 0, go to RESP; otherwise go to WAIT with wcnt = WAIT_CYCLES − 1.
- WAIT: wcnt decrements each edge. At wcnt = 0 the FSM goes to RESP.
- Entering RESP performs the access at that same edge:
  - a store updates the target; a load registers rdata.
  - ready = 1 for exactly the RESP cycle.
- RESP: always returns to IDLE at the next edge, whatever req is. A held req is never serviced twice.
- Latency: req first seen at edge E0 gives ready high in the cycle after edge E0 + WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES + 2 cycles. A new request is accepted at the earliest at the edge that leaves RESP.
- Address decode uses the latched address:
  - addr[31:2] < DEPTH selects the RAM word addr[log2(DEPTH)+1:2].
  - addr == LED_ADDR selects the LED register. Stores write wdata[15:0]; loads return {16'b0, led}.
  - addr == CNT_ADDR selects the counter. Loads return the count; stores are ignored and do not set err.
  - Any other address is unmapped: loads return 0, stores are dropped, err is set.
- Misaligned access (addr[1:0] ≠ 0):
  - no RAM or register update;
  - rdata = 0;
  - err set;
  - ready still pulses so the core never hangs.
- err clears only on reset.
- Inputs changing while in WAIT: ignored; the latched copy is used.
- Reset mid-operation: FSM returns to IDLE, ready = 0 on the next cycle, and the pending store is discarded.
- Core drops req before ready: the access still completes and ready still pulses.
- rdata holds its value outside RESP; the core must not use it then.

Optional Feature:
- Macro: DMEM_CYCLE_COUNTER_EN.
- When defined:
  - a 32-bit counter increments every clk edge and wraps 32'hFFFF_FFFF → 0;
  - reset clears it to 0;
  - a load at CNT_ADDR returns the value sampled at the RESP-entry edge.
- When undefined:
  - no counter logic is built;
  - CNT_ADDR is treated as unmapped: loads return 0 and set err, stores set err.

Test Plan:
- WAIT_CYCLES = 2: store 32'hDEADBEEF at 0x10, then load 0x10. Required: ready high exactly 3 cycles after each request's first edge, and the load returns 32'hDEADBEEF with err = 0.
- WAIT_CYCLES = 0: hold req high with we = 0 across 6 cycles. Required: ready pattern 0,1,0,1,0,1 and no double service of one request.
- Store 32'h1234ABCD to LED_ADDR. Required: led = 16'hABCD after the RESP edge, and a following load returns 32'h0000ABCD.
- Load 0x13 (misaligned), then store to 0x0000_1000 with DEPTH = 64 (unmapped). Required: ready pulses for both, rdata = 0, err = 1 and stays 1, RAM word 4 unchanged.
- Assert reset during WAIT of a store of 32'h55 to 0x08. Required: ready never pulses, and a later load of 0x08 returns the pre-reset RAM value.
- With DMEM_CYCLE_COUNTER_EN: two loads of CNT_ADDR at WAIT_CYCLES = 1. Required: the values differ by exactly the cycle spacing of their RESP edges (3 for back-to-back requests), and err = 0. Without the macro: a load returns 0 and err = 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: word RAM plus LED/counter MMIO, one-cycle ready pulse.
// Optional free-running cycle counter at CNT_ADDR enabled by `define DMEM_CYCLE_COUNTER_EN.
module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FF00,
  parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [15:0] led
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] l_addr, l_wdata;
  logic        l_we;

  logic [31:0] mem [DEPTH];

  logic [31:0] a_addr, a_wdata;
  logic        a_we;
  logic        access;
  logic        misaligned, hit_ram, hit_led, hit_cnt, mapped;
  logic [AW-1:0] ram_idx;
  logic [31:0] cnt_val;
  logic [31:0] rd_val;

  // With zero wait states the access happens at the accepting edge, so the
  // live inputs are used there; every later edge uses the latched copy.
  always_comb begin
    a_addr  = l_addr;
    a_we    = l_we;
    a_wdata = l_wdata;
    if (state == S_IDLE) begin
      a_addr  = addr;
      a_we    = we;
      a_wdata = wdata;
    end
  end

  assign access = !reset &&
                  (((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && (wcnt == 4'd0)));

  assign misaligned = |a_addr[1:0];
  assign hit_ram    = (a_addr[31:2] < 30'(DEPTH));
  assign hit_led    = (a_addr == LED_ADDR);
  assign ram_idx    = a_addr[AW+1:2];

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) cnt <= 32'd0;
    else       cnt <= cnt + 32'd1;
  end

  assign hit_cnt = (a_addr == CNT_ADDR);
  assign cnt_val = cnt;
`else
  assign hit_cnt = 1'b0 & (a_addr == CNT_ADDR);
  assign cnt_val = 32'd0;
`endif

  assign mapped = hit_ram || hit_led || hit_cnt;

  always_comb begin
    rd_val = 32'd0;
    if (hit_ram)      rd_val = mem[ram_idx];
    else if (hit_led) rd_val = {16'b0, led};
    else if (hit_cnt) rd_val = cnt_val;
  end

  // NOTE: the RAM array has no reset; clearing it would forbid block-RAM mapping,
  // and software must not rely on its power-up contents anyway.
  always_ff @(posedge clk) begin
    if (access && a_we && !misaligned && hit_ram)
      mem[ram_idx] <= a_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      l_we    <= 1'b0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      err     <= 1'b0;
      led     <= 16'd0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            l_addr  <= addr;
            l_we    <= we;
            l_wdata <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              wcnt  <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_RESP;
          else              wcnt  <= wcnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (access) begin
        ready <= 1'b1;
        if (misaligned) begin
          rdata <= 32'd0;
          err   <= 1'b1;
        end else if (a_we) begin
          if (hit_led) led <= a_wdata[15:0];
          if (!mapped) err <= 1'b1;
        end else begin
          rdata <= rd_val;
          if (!mapped) err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with 0, 1 and 2 wait states,
// table-driven accesses through a scoreboard plus hand-written corner-case sequences.
module tb_dmem_responder;

  localparam logic [31:0] LED_A = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_A = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we, ready, err;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [15:0] led   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance index equals its wait-state count.
  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .led(led[0]));
  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .led(led[1]));
  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .led(led[2]));

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request on instance v.d, wait (bounded) for ready, then compare
  // against the scoreboard entry pushed when the stimulus was driven.
  task automatic access(input vec_t v, input string name);
    int   n;
    bit   seen;
    exp_t e;
    @(negedge clk);
    req[v.d] = 1'b1; we[v.d] = v.w; addr[v.d] = v.a; wdata[v.d] = v.wd;
    sb.push_back('{v.chk_rd, v.exp_rd, v.exp_err, v.d + 1});
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready[v.d]) seen = 1;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no ready within 40 cycles", name);
    end else begin
      check({name, " latency"}, 32'(n), 32'(e.lat));
      if (e.chk_rd) check({name, " rdata"}, rdata[v.d], e.rd);
      check({name, " err"}, 32'(err[v.d]), 32'(e.e));
    end
    @(negedge clk);
    req[v.d] = 1'b0;
  endtask

  vec_t vecs_a [9];
  vec_t vecs_b [3];

  initial begin
    int   n;
    bit   saw;
    logic [31:0] c1, c2;

    vecs_a[0] = '{2, 1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs_a[1] = '{2, 1'b0, 32'h10,  32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs_a[2] = '{2, 1'b1, LED_A,   32'h1234_ABCD, 1'b0, 32'h0,         1'b0};
    vecs_a[3] = '{2, 1'b0, LED_A,   32'h0,         1'b1, 32'h0000_ABCD, 1'b0};
    vecs_a[4] = '{2, 1'b1, 32'h08,  32'h0000_0077, 1'b0, 32'h0,         1'b0};
    vecs_a[5] = '{2, 1'b0, 32'h08,  32'h0,         1'b1, 32'h0000_0077, 1'b0};
    vecs_a[6] = '{0, 1'b1, 32'h20,  32'hA5A5_0001, 1'b0, 32'h0,         1'b0};
    vecs_a[7] = '{0, 1'b0, 32'h20,  32'h0,         1'b1, 32'hA5A5_0001, 1'b0};
    vecs_a[8] = '{1, 1'b1, 32'hFC,  32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};

    vecs_b[0] = '{2, 1'b0, 32'h13,   32'h0,         1'b1, 32'h0,         1'b1};
    vecs_b[1] = '{2, 1'b1, 32'h1000, 32'h1111_2222, 1'b1, 32'h0,         1'b1};
    vecs_b[2] = '{2, 1'b0, 32'h10,   32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};

    req = '0; we = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = 32'h0; wdata[i] = 32'h0; end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready[%0d]", i), 32'(ready[i]), 32'h0);
      check($sformatf("reset err[%0d]", i),   32'(err[i]),   32'h0);
      check($sformatf("reset led[%0d]", i),   32'(led[i]),   32'h0);
      check($sformatf("reset rdata[%0d]", i), rdata[i],      32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      access(vecs_a[i], $sformatf("vec_a%0d", i));
      if (i == 2) check("led after store", 32'(led[2]), 32'h0000_ABCD);
    end
    access('{1, 1'b0, 32'hFC, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0}, "last word load");

    // Zero wait states with req held: one service every second cycle, never twice.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = LED_A;
    check("held ready s0", 32'(ready[0]), 32'h0);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("held ready s%0d", i), 32'(ready[0]), 32'(i % 2));
    end
    @(negedge clk);
    req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held req released", 32'(ready[0]), 32'h0);

    // Reset while a store of 0x55 to 0x08 sits in WAIT: no ready, RAM untouched.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h08; wdata[2] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req[2] = 1'b0;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready[2]) saw = 1;
      if (i == 1) begin
        @(negedge clk);
        reset = 1'b0;
      end
    end
    check("reset mid-store ready", 32'(saw), 32'h0);
    check("reset clears led", 32'(led[2]), 32'h0);
    access('{2, 1'b0, 32'h08, 32'h0, 1'b1, 32'h0000_0077, 1'b0}, "post-reset load");

    for (int i = 0; i < 3; i++) access(vecs_b[i], $sformatf("vec_b%0d", i));
    check("err sticky", 32'(err[2]), 32'h1);

`ifdef DMEM_CYCLE_COUNTER_EN
    // Back-to-back counter loads at one wait state: RESP edges three cycles apart.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = CNT_A;
    n = 0; saw = 0;
    while (!saw && n < 40) begin @(posedge clk); #1; n++; saw = ready[1]; end
    check("cnt first ready", 32'(saw), 32'h1);
    c1 = rdata[1];
    n = 0; saw = 0;
    while (!saw && n < 40) begin @(posedge clk); #1; n++; saw = ready[1]; end
    check("cnt second ready", 32'(saw), 32'h1);
    c2 = rdata[1];
    @(negedge clk);
    req[1] = 1'b0;
    check("cnt spacing", 32'(n), 32'd3);
    check("cnt delta", c2 - c1, 32'd3);
    check("cnt err", 32'(err[1]), 32'h0);
    access('{1, 1'b1, CNT_A, 32'h1234, 1'b0, 32'h0, 1'b0}, "cnt store ignored");
`else
    access('{1, 1'b0, CNT_A, 32'h0, 1'b1, 32'h0, 1'b1}, "cnt unmapped load");
`endif

    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
